// File: rtl/simplez_uart_tx_port.sv
// simplez_uart_tx_port: SIMPLEZ memory-mapped UART transmitter.
// Ports:
//   clk (state updates on its falling edge), rstn (sync, active-low),
//   addr/data_in/we/re (CPU bus), sel (address decode),
//   data_out (registered read data), tx (serial line, idle high).
// Bus behaviour:
//   Writes to DATA_ADDR queue data_in[7:0] in a FIFO for 8N1 transmission.
//   Reads of STATUS_ADDR return {overflow, idle, ready}.
// Macro SIMPLEZ_UART_PARITY_EN adds an even-parity bit before the stop bit.
module simplez_uart_tx_port #(
  parameter int ADDRW = 9,
  parameter int DATAW = 12,
  parameter int STATUS_ADDR = 508,
  parameter int DATA_ADDR = 509,
  parameter int BAUD_DIV = 104,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [ADDRW-1:0] addr,
  input  logic [DATAW-1:0] data_in,
  input  logic             we,
  input  logic             re,
  output logic             sel,
  output logic [DATAW-1:0] data_out,
  output logic             tx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD_DIV);
`ifdef SIMPLEZ_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, nxt;
  logic [7:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic [CW-1:0] bc;
  logic [2:0] idx;
  logic [7:0] sh;
  logic [7:0] last_char;
  logic overflow, full, empty, wr, push, pop, tick, rd_st, idle;
  logic [DATAW-1:0] status;
  logic unused_hi;
  assign unused_hi = ^data_in[DATAW-1:8];
  assign sel = addr == ADDRW'(STATUS_ADDR) || addr == ADDRW'(DATA_ADDR);
  assign full = cnt == (PW+1)'(FIFO_DEPTH);
  assign empty = cnt == '0;
  assign wr = we && addr == ADDRW'(DATA_ADDR);
  assign push = wr && !full;
  assign rd_st = re && addr == ADDRW'(STATUS_ADDR);
  assign tick = bc == CW'(BAUD_DIV - 1);
  assign idle = empty && state == IDLE;
  assign status = {{(DATAW-3){1'b0}}, overflow, idle, !full};
  // sh keeps the whole character; idx selects the bit being sent
`ifdef SIMPLEZ_UART_PARITY_EN
  assign tx = state == START ? 1'b0 : state == DATA ? sh[idx] : state == PARITY ? ^sh : 1'b1;
`else
  assign tx = state == START ? 1'b0 : state == DATA ? sh[idx] : 1'b1;
`endif
  always_comb begin
    nxt = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty;
        nxt = empty ? IDLE : START;
      end
      START: nxt = tick ? DATA : START;
      DATA: nxt = tick && idx == 3'd7 ? AFTER_DATA : DATA;
`ifdef SIMPLEZ_UART_PARITY_EN
      PARITY: nxt = tick ? STOP : PARITY;
`endif
      STOP: begin
        // chain straight into the next frame when more data is queued
        pop = tick && !empty;
        nxt = !tick ? STOP : empty ? IDLE : START;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(negedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      bc <= '0;
      idx <= '0;
      sh <= '0;
      overflow <= 1'b0;
      last_char <= '0;
      data_out <= '0;
    end else begin
      state <= nxt;
      if (push) begin
        mem[wp] <= data_in[7:0];
        wp <= wp + 1'b1;
      end
      if (pop) begin
        sh <= mem[rp];
        rp <= rp + 1'b1;
      end
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      bc <= (state == IDLE || tick) ? '0 : bc + 1'b1;
      if (state == DATA && tick) idx <= idx + 3'd1;
      if (wr) last_char <= data_in[7:0];
      // a dropped write in the same cycle as a status read keeps the flag set
      overflow <= (wr && full) || (overflow && !rd_st);
      if (re) data_out <= rd_st ? status : addr == ADDRW'(DATA_ADDR) ? {{(DATAW-8){1'b0}}, last_char} : '0;
    end
  end
endmodule

// File: tb/tb_simplez_uart_tx_port.sv
// tb_simplez_uart_tx_port: scoreboard bench for simplez_uart_tx_port at BAUD_DIV=4, FIFO_DEPTH=4.
module tb_simplez_uart_tx_port;
  localparam int B = 4;
`ifdef SIMPLEZ_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * B;
  logic clk = 1'b0, rstn = 1'b0, we = 1'b0, re = 1'b0, sel, tx;
  logic [8:0] addr = '0;
  logic [11:0] data_in = '0, data_out;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [7:0] c; int st;} ch_t;
  ch_t charq[$];
  ch_t e;
  logic [11:0] rdq[$];
  bit rd_pend = 1'b0, rst_seen = 1'b1, busy = 1'b0;
  int k, st;
  logic [7:0] sh;

  simplez_uart_tx_port #(.BAUD_DIV(B), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .data_in(data_in), .we(we), .re(re),
    .sel(sel), .data_out(data_out), .tx(tx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    rd_pend <= re;
    rst_seen <= !rstn;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst_seen) busy = 1'b0;
    else if (!busy) begin
      if (tx === 1'b0) begin
        busy = 1'b1;
        k = 0;
        st = cyc;
      end
    end else begin
      k++;
      if (k == 2) chk("start_bit", tx, 0);
      if (k >= 5 && k <= 33 && k % 4 == 1) sh[3'((k - 5) / 4)] = tx;
`ifdef SIMPLEZ_UART_PARITY_EN
      if (k == 37) chk("parity_bit", tx, ^sh);
`endif
      if (k == F - 3) begin
        chk("stop_bit", tx, 1);
        busy = 1'b0;
        if (charq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got char 0x%0h expected none", sh);
        end else begin
          e = charq.pop_front();
          chk("char", sh, e.c);
          chk("start_cycle", st, e.st);
        end
      end
    end
  end

  always @(posedge clk) if (rd_pend) begin
    if (rdq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_read: got 0x%0h expected none", data_out);
    end else chk("read_data", data_out, rdq.pop_front());
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      we = 1'b0;
      re = 1'b0;
    end
  endtask

  task automatic wr(input int a, input int d, output int n);
    @(posedge clk);
    re = 1'b0;
    we = 1'b1;
    addr = 9'(a);
    data_in = 12'(d);
    n = cyc + 1;
  endtask

  task automatic rd(input int a, input int exp);
    @(posedge clk);
    we = 1'b0;
    re = 1'b1;
    addr = 9'(a);
    rdq.push_back(12'(exp));
    #1 chk("sel", sel, a == 508 || a == 509);
  endtask

  task automatic drain();
    for (int i = 0; i < 6 * F + 50 && charq.size() > 0; i++) @(posedge clk);
    chk("drain", charq.size(), 0);
    idle(B);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, s;
    repeat (4) @(posedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_dout", data_out, 0);
    rstn = 1'b1;
    rd(508, 'h003);
    wr(509, 'h155, n);
    charq.push_back('{c: 8'h55, st: n + 1});
    rd(509, 'h055);
    rd(508, 'h001);
    idle(F + 4);
    rd(508, 'h003);
    idle(1);
    for (int i = 0; i < 6; i++) begin
      wr(509, 'h30 + i, n);
      if (i == 0) s = n + 1;
      if (i < 5) charq.push_back('{c: 8'(8'h30 + i), st: s + i * F});
    end
    rd(508, 'h004);
    rd(508, 'h000);
    idle(1);
    drain();
    rd(508, 'h003);
    wr(509, 'h0A5, n);
    s = n + 1;
    charq.push_back('{c: 8'hA5, st: s});
    idle(1);
    wr(509, 'h03C, n);
    charq.push_back('{c: 8'h3C, st: s + F});
    idle(1);
    drain();
    wr(509, 'h0F0, n);
    idle(1);
    wr(509, 'h00F, n);
    idle(4 * B);
    @(posedge clk);
    rstn = 1'b0;
    @(posedge clk);
    chk("abort_tx", tx, 1);
    rstn = 1'b1;
    rd(508, 'h003);
    idle(F + 10);
    chk("abort_tx_idle", tx, 1);
`ifdef SIMPLEZ_UART_PARITY_EN
    wr(509, 'h007, n);
    charq.push_back('{c: 8'h07, st: n + 1});
    idle(1);
    drain();
`endif
    idle(F);
    chk("rdq_empty", rdq.size(), 0);
    chk("charq_empty", charq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
